// File: rtl/avmm_ccip_host_ordered.sv
// avmm_ccip_host_ordered: AVST command stream to CCI-P bridge with in-order read reorder buffer
package ccip_if_pkg;
  typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
  typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1} t_ccip_c1_req;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
  typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4} t_ccip_c1_rsp;
  typedef enum logic [1:0] {eVC_VA = 2'd0, eVC_VL0 = 2'd1, eVC_VH0 = 2'd2, eVC_VH1 = 2'd3} t_ccip_vc;
  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   cl_len;
    t_ccip_c0_req req_type;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c0_ReqMemHdr;
  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic         sop;
    logic [1:0]   cl_len;
    t_ccip_c1_req req_type;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;
  typedef struct packed {
    t_ccip_vc     vc_used;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c0_RspMemHdr;
  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         format;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;
  typedef struct packed {t_ccip_c0_ReqMemHdr hdr; logic valid;} t_if_ccip_c0_Tx;
  typedef struct packed {t_ccip_c1_ReqMemHdr hdr; logic [511:0] data; logic valid;} t_if_ccip_c1_Tx;
  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;
  typedef struct packed {t_ccip_c1_RspMemHdr hdr; logic rspValid;} t_if_ccip_c1_Rx;
endpackage

module avmm_ccip_host_ordered
  import ccip_if_pkg::*;
#(
  parameter int AVMM_ADDR_WIDTH = 48,
  parameter int AVMM_DATA_WIDTH = 512,
  parameter int AVMM_BURST_WIDTH = 3,
  parameter int ROB_DEPTH = 64,
  parameter int WR_CNT_WIDTH = 32,
  localparam int OUTPUT_AVST_WIDTH = AVMM_ADDR_WIDTH + AVMM_DATA_WIDTH + AVMM_BURST_WIDTH + 1,
  localparam int CW = $clog2(ROB_DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [OUTPUT_AVST_WIDTH-1:0] avst_avcmd_data,
  input  logic                         avst_avcmd_valid,
  output logic                         avst_avcmd_ready,
  output logic [AVMM_DATA_WIDTH-1:0]   avst_rd_rsp_data,
  output logic                         avst_rd_rsp_valid,
  input  logic                         avst_rd_rsp_ready,
  input  logic                         c0TxAlmFull,
  input  logic                         c1TxAlmFull,
  input  t_if_ccip_c0_Rx               c0rx,
  input  t_if_ccip_c1_Rx               c1rx,
  output t_if_ccip_c0_Tx               c0tx,
  output t_if_ccip_c1_Tx               c1tx,
  output logic [CW:0]                  rd_lines_outstanding,
  output logic [WR_CNT_WIDTH-1:0]      wr_lines_completed
);
  typedef enum logic {IDLE, IN_BURST} t_wst;
  logic cmd_rd;
  logic [AVMM_ADDR_WIDTH-1:0] cmd_addr;
  logic [AVMM_DATA_WIDTH-1:0] cmd_wdata;
  logic [AVMM_BURST_WIDTH-1:0] cmd_burst;
  logic [41:0] line;
  logic [2:0] len;
  logic ready_q, rd_acc, wr_acc, first, rsp_ok, load;
  t_wst st_q;
  logic [1:0] beat_q, wlen_q;
  logic [41:0] base_q;
  logic [15:0] wr_mdata_q;
  logic [AVMM_DATA_WIDTH-1:0] rob_q [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] rob_v_q;
  logic [CW-1:0] head_q, tail_q, rsp_idx;
  logic [CW:0] alloc_q, alloc_d;
  logic out_valid_q;
  logic [AVMM_DATA_WIDTH-1:0] out_data_q;
  logic [WR_CNT_WIDTH-1:0] wr_cnt_q;
  t_ccip_c0_ReqMemHdr c0_hdr_q;
  t_ccip_c1_ReqMemHdr c1_hdr_q;
  logic [AVMM_DATA_WIDTH-1:0] c1_data_q;
  logic c0_v_q, c1_v_q;
  logic unused;
  assign {cmd_addr, cmd_wdata, cmd_burst, cmd_rd} = avst_avcmd_data;
  assign line = cmd_addr[AVMM_ADDR_WIDTH-1:6];
  assign len = (cmd_burst == AVMM_BURST_WIDTH'(2)) ? 3'd2 : (cmd_burst == AVMM_BURST_WIDTH'(4)) ? 3'd4 : 3'd1;
  assign avst_avcmd_ready = ready_q && !(st_q == IN_BURST && cmd_rd);
  assign rd_acc = avst_avcmd_valid && avst_avcmd_ready && cmd_rd;
  assign wr_acc = avst_avcmd_valid && avst_avcmd_ready && !cmd_rd;
  assign first = st_q == IDLE;
  assign rsp_ok = c0rx.rspValid && c0rx.hdr.resp_type == eRSP_RDLINE;
  assign rsp_idx = c0rx.hdr.mdata[CW-1:0] + CW'(c0rx.hdr.cl_num);
  assign load = rob_v_q[head_q] && (!out_valid_q || avst_rd_rsp_ready);
  assign alloc_d = alloc_q + (rd_acc ? (CW+1)'(len) : '0) - (CW+1)'(load);
  assign avst_rd_rsp_valid = out_valid_q;
  assign avst_rd_rsp_data = out_data_q;
  assign c0tx = '{hdr: c0_hdr_q, valid: c0_v_q};
  assign c1tx = '{hdr: c1_hdr_q, data: c1_data_q, valid: c1_v_q};
  assign rd_lines_outstanding = alloc_q;
  assign wr_lines_completed = wr_cnt_q;
  assign unused = ^{cmd_addr[5:0], c0rx.hdr.vc_used, c0rx.hdr.mdata[15:CW], c0rx.mmioRdValid,
                    c0rx.mmioWrValid, c1rx.hdr.vc_used, c1rx.hdr.mdata};
  // Control state: ready gate, ROB pointers and valid bits, write burst FSM, completion counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
      c0_v_q <= 1'b0;
      c1_v_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      alloc_q <= '0;
      rob_v_q <= '0;
      out_valid_q <= 1'b0;
      st_q <= IDLE;
      beat_q <= '0;
      wlen_q <= '0;
      base_q <= '0;
      wr_mdata_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      ready_q <= !(c0TxAlmFull || c1TxAlmFull) && alloc_d <= (CW+1)'(ROB_DEPTH - 4);
      c0_v_q <= rd_acc;
      c1_v_q <= wr_acc;
      alloc_q <= alloc_d;
      if (rd_acc) tail_q <= tail_q + CW'(len);
      if (load) head_q <= head_q + 1'b1;
      if (load) rob_v_q[head_q] <= 1'b0;
      if (rsp_ok) rob_v_q[rsp_idx] <= 1'b1;
      out_valid_q <= load || (out_valid_q && !avst_rd_rsp_ready);
      if (wr_acc) begin
        wr_mdata_q <= wr_mdata_q + 1'b1;
        if (first) begin
          base_q <= line;
          wlen_q <= 2'(len - 3'd1);
          beat_q <= 2'd1;
          st_q <= len > 3'd1 ? IN_BURST : IDLE;
        end else begin
          beat_q <= beat_q + 1'b1;
          st_q <= beat_q == wlen_q ? IDLE : IN_BURST;
        end
      end
      if (c1rx.rspValid && c1rx.hdr.resp_type == eRSP_WRLINE)
        wr_cnt_q <= wr_cnt_q + (c1rx.hdr.format ? WR_CNT_WIDTH'(c1rx.hdr.cl_num) + WR_CNT_WIDTH'(1) : WR_CNT_WIDTH'(1));
    end
  end
  // Datapath: ROB storage, drain register, request headers and write data
  always_ff @(posedge clk) begin
    if (rsp_ok) rob_q[rsp_idx] <= c0rx.data;
    if (load) out_data_q <= rob_q[head_q];
    if (rd_acc) c0_hdr_q <= '{vc_sel: eVC_VH0, cl_len: 2'(len - 3'd1), req_type: eREQ_RDLINE_I,
                             address: line, mdata: 16'(tail_q)};
    if (wr_acc) begin
      c1_hdr_q <= '{vc_sel: eVC_VH0, sop: first, cl_len: first ? 2'(len - 3'd1) : wlen_q,
                    req_type: eREQ_WRLINE_I,
                    address: first ? line : {base_q[41:2], base_q[1:0] + beat_q}, mdata: wr_mdata_q};
      c1_data_q <= cmd_wdata;
    end
  end
endmodule

// File: tb/tb_avmm_ccip_host_ordered.sv
// tb_avmm_ccip_host_ordered: directed self-checking bench for the ordered CCI-P host bridge
module tb_avmm_ccip_host_ordered;
  import ccip_if_pkg::*;
  localparam int OW = 48 + 512 + 3 + 1;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [OW-1:0] cmd;
  logic cmd_v, rsp_rdy, alm0, alm1;
  t_if_ccip_c0_Rx c0rx;
  t_if_ccip_c1_Rx c1rx;
  logic rdy_a, ov_a, rdy_b, ov_b;
  logic [511:0] od_a, od_b;
  t_if_ccip_c0_Tx c0tx_a, c0tx_b;
  t_if_ccip_c1_Tx c1tx_a, c1tx_b;
  logic [6:0] out_a;
  logic [3:0] out_b;
  logic [31:0] wc_a, wc_b;
  int n_cmp = 0;
  int n_err = 0;
  int got;

  always #5 clk = ~clk;

  avmm_ccip_host_ordered #(.ROB_DEPTH(64)) u_a (
    .clk(clk), .reset_n(reset_n), .avst_avcmd_data(cmd), .avst_avcmd_valid(cmd_v),
    .avst_avcmd_ready(rdy_a), .avst_rd_rsp_data(od_a), .avst_rd_rsp_valid(ov_a),
    .avst_rd_rsp_ready(rsp_rdy), .c0TxAlmFull(alm0), .c1TxAlmFull(alm1), .c0rx(c0rx),
    .c1rx(c1rx), .c0tx(c0tx_a), .c1tx(c1tx_a), .rd_lines_outstanding(out_a),
    .wr_lines_completed(wc_a));

  avmm_ccip_host_ordered #(.ROB_DEPTH(8)) u_b (
    .clk(clk), .reset_n(reset_n), .avst_avcmd_data(cmd), .avst_avcmd_valid(cmd_v),
    .avst_avcmd_ready(rdy_b), .avst_rd_rsp_data(od_b), .avst_rd_rsp_valid(ov_b),
    .avst_rd_rsp_ready(rsp_rdy), .c0TxAlmFull(alm0), .c1TxAlmFull(alm1), .c0rx(c0rx),
    .c1rx(c1rx), .c0tx(c0tx_b), .c1tx(c1tx_b), .rd_lines_outstanding(out_b),
    .wr_lines_completed(wc_b));

  function automatic logic [511:0] dat(input int k);
    return {8{64'h5A5A_0000_0000_0000 + 64'(k)}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_rd(input logic [47:0] a, input logic [2:0] l);
    cmd = {a, 512'd0, l, 1'b1};
    cmd_v = 1'b1;
    tick;
    cmd_v = 1'b0;
  endtask

  task automatic rsp(input logic [15:0] md, input logic [1:0] cl, input logic [511:0] d);
    c0rx = '0;
    c0rx.hdr.mdata = md;
    c0rx.hdr.cl_num = cl;
    c0rx.hdr.resp_type = eRSP_RDLINE;
    c0rx.data = d;
    c0rx.rspValid = 1'b1;
    tick;
    c0rx = '0;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    cmd_v = 1'b0;
    alm0 = 1'b0;
    alm1 = 1'b0;
    rsp_rdy = 1'b1;
    c0rx = '0;
    c1rx = '0;
    tick;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  initial begin
    logic [15:0] md2 [7];
    logic [1:0] cl2 [7];
    logic [15:0] md3 [8];
    logic [1:0] cl3 [8];
    int ord3 [8];
    logic [41:0] wexp [3];
    md2 = '{16'd6, 16'd4, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
    cl2 = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1};
    md3 = '{16'd0, 16'd0, 16'd4, 16'd4, 16'd6, 16'd6, 16'd6, 16'd6};
    cl3 = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0};
    ord3 = '{0, 1, 2, 3, 7, 6, 5, 4};
    wexp = '{42'h83, 42'h80, 42'h81};
    cmd = '0;
    cmd_v = 1'b0;
    rsp_rdy = 1'b1;
    alm0 = 1'b0;
    alm1 = 1'b0;
    c0rx = '0;
    c1rx = '0;
    tick;
    tick;
    chk("rst_ready", rdy_a, 0);
    chk("rst_c0v", c0tx_a.valid, 0);
    chk("rst_c1v", c1tx_a.valid, 0);
    chk("rst_rspv", ov_a, 0);
    chk("rst_out", out_a, 0);
    chk("rst_wc", wc_a, 0);
    chk("rst_ready_b", rdy_b, 0);
    reset_n = 1'b1;
    tick;
    chk("ready_up", rdy_a, 1);

    send_rd(48'h1000, 3'd1);
    chk("r1_c0v", c0tx_a.valid, 1);
    chk("r1_addr", c0tx_a.hdr.address, 42'h40);
    chk("r1_mdata", c0tx_a.hdr.mdata, 0);
    chk("r1_len", c0tx_a.hdr.cl_len, 0);
    chk("r1_type", c0tx_a.hdr.req_type, eREQ_RDLINE_I);
    chk("r1_vc", c0tx_a.hdr.vc_sel, eVC_VH0);
    chk("r1_out1", out_a, 1);
    tick;
    chk("r1_c0v_low", c0tx_a.valid, 0);
    tick;
    rsp(16'd0, 2'd0, dat(1));
    chk("r1_lat1", ov_a, 0);
    tick;
    chk("r1_lat2", ov_a, 1);
    chk("r1_data", od_a, dat(1));
    chk("r1_out0", out_a, 0);
    tick;
    chk("r1_done", ov_a, 0);

    do_reset;
    send_rd(48'h0, 3'd4);
    chk("o_md0", c0tx_a.hdr.mdata, 0);
    chk("o_len4", c0tx_a.hdr.cl_len, 3);
    send_rd(48'h4000, 3'd2);
    chk("o_md4", c0tx_a.hdr.mdata, 4);
    chk("o_len2", c0tx_a.hdr.cl_len, 1);
    send_rd(48'h8000, 3'd1);
    chk("o_md6", c0tx_a.hdr.mdata, 6);
    chk("o_out7", out_a, 7);
    got = 0;
    for (int i = 0; i < 7; i++) begin
      rsp(md2[i], cl2[i], dat(int'(md2[i]) + int'(cl2[i])));
      if (i < 5) chk("o_early", ov_a, 0);
      if (ov_a) begin
        chk("o_order", od_a, dat(got));
        got++;
      end
    end
    for (int i = 0; i < 20 && got < 7; i++) begin
      tick;
      if (ov_a) begin
        chk("o_order", od_a, dat(got));
        got++;
      end
    end
    chk("o_count", got, 7);
    chk("o_out0", out_a, 0);

    do_reset;
    send_rd(48'h0, 3'd4);
    chk("f_ready4", rdy_b, 1);
    send_rd(48'h400, 3'd2);
    chk("f_md4", c0tx_b.hdr.mdata, 4);
    chk("f_ready_low", rdy_b, 0);
    chk("f_out6", out_b, 6);
    cmd = {48'h0, 512'd0, 3'd1, 1'b1};
    cmd_v = 1'b1;
    tick;
    cmd_v = 1'b0;
    chk("f_blocked", c0tx_b.valid, 0);
    rsp(16'd0, 2'd0, dat(0));
    rsp(16'd0, 2'd1, dat(1));
    chk("f_still_low", rdy_b, 0);
    chk("f_drain0", od_b, dat(0));
    tick;
    chk("f_ready_back", rdy_b, 1);
    chk("f_out4", out_b, 4);
    chk("f_drain1", od_b, dat(1));
    send_rd(48'h800, 3'd4);
    chk("f_wrap_md", c0tx_b.hdr.mdata, 6);
    chk("f_out8", out_b, 8);
    chk("f_ready_full", rdy_b, 0);
    got = 0;
    for (int i = 0; i < 8; i++) begin
      rsp(md3[i], cl3[i], dat(20 + ord3[i]));
      if (ov_b) begin
        chk("f_order", od_b, dat(20 + got));
        got++;
      end
    end
    for (int i = 0; i < 20 && got < 8; i++) begin
      tick;
      if (ov_b) begin
        chk("f_order", od_b, dat(20 + got));
        got++;
      end
    end
    chk("f_count", got, 8);
    chk("f_out0", out_b, 0);

    do_reset;
    send_rd(48'h0, 3'd4);
    rsp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) rsp(16'd0, 2'(i), dat(40 + i));
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_valid", ov_a, 1);
      chk("bp_hold", od_a, dat(40));
    end
    chk("bp_out3", out_a, 3);
    rsp_rdy = 1'b1;
    chk("bp_b0", od_a, dat(40));
    for (int i = 1; i < 4; i++) begin
      tick;
      chk("bp_bv", ov_a, 1);
      chk("bp_bd", od_a, dat(40 + i));
    end
    tick;
    chk("bp_end", ov_a, 0);
    chk("bp_out0", out_a, 0);

    do_reset;
    cmd = {48'h2080, dat(60), 3'd4, 1'b0};
    cmd_v = 1'b1;
    tick;
    chk("w0_v", c1tx_a.valid, 1);
    chk("w0_sop", c1tx_a.hdr.sop, 1);
    chk("w0_addr", c1tx_a.hdr.address, 42'h82);
    chk("w0_len", c1tx_a.hdr.cl_len, 3);
    chk("w0_data", c1tx_a.data, dat(60));
    chk("w0_md", c1tx_a.hdr.mdata, 0);
    chk("w0_type", c1tx_a.hdr.req_type, eREQ_WRLINE_I);
    cmd = {48'h0, 512'd0, 3'd1, 1'b1};
    #1;
    chk("w_rd_gate", rdy_a, 0);
    tick;
    chk("w_rd_c0v", c0tx_a.valid, 0);
    chk("w_rd_c1v", c1tx_a.valid, 0);
    for (int j = 0; j < 3; j++) begin
      cmd = {48'h0, dat(61 + j), 3'd1, 1'b0};
      tick;
      chk("wb_v", c1tx_a.valid, 1);
      chk("wb_sop", c1tx_a.hdr.sop, 0);
      chk("wb_addr", c1tx_a.hdr.address, wexp[j]);
      chk("wb_len", c1tx_a.hdr.cl_len, 3);
      chk("wb_data", c1tx_a.data, dat(61 + j));
      chk("wb_md", c1tx_a.hdr.mdata, 1 + j);
    end
    cmd_v = 1'b0;
    cmd = {48'h0, 512'd0, 3'd1, 1'b1};
    tick;
    chk("w_end_v", c1tx_a.valid, 0);
    chk("w_rd_ok", rdy_a, 1);
    c1rx = '0;
    c1rx.hdr.format = 1'b1;
    c1rx.hdr.cl_num = 2'd3;
    c1rx.hdr.resp_type = eRSP_WRLINE;
    c1rx.rspValid = 1'b1;
    tick;
    chk("wc_packed", wc_a, 4);
    c1rx.hdr.format = 1'b0;
    tick;
    chk("wc_single", wc_a, 5);
    c1rx.hdr.resp_type = eRSP_WRFENCE;
    tick;
    c1rx = '0;
    chk("wc_fence", wc_a, 5);
    c0rx = '0;
    c0rx.hdr.resp_type = eRSP_UMSG;
    c0rx.data = dat(99);
    c0rx.rspValid = 1'b1;
    tick;
    c0rx = '0;
    tick;
    tick;
    chk("umsg_ign", ov_a, 0);

    send_rd(48'h3000, 3'd2);
    chk("a_out2", out_a, 2);
    alm0 = 1'b1;
    tick;
    chk("a_ready", rdy_a, 0);
    cmd = {48'h5000, 512'd0, 3'd1, 1'b1};
    cmd_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("a_noreq", c0tx_a.valid, 0);
    end
    cmd_v = 1'b0;
    chk("a_out_hold", out_a, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("x_ready", rdy_a, 0);
    chk("x_c0v", c0tx_a.valid, 0);
    chk("x_c1v", c1tx_a.valid, 0);
    chk("x_rspv", ov_a, 0);
    chk("x_out", out_a, 0);
    chk("x_wc", wc_a, 0);
    chk("x_out_b", out_b, 0);
    tick;
    reset_n = 1'b1;
    alm0 = 1'b0;
    tick;
    tick;
    chk("x_ready_up", rdy_a, 1);
    chk("x_out_post", out_a, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
